// File: rtl/note_sequencer.sv
// Multi-voice pattern sequencer: one scan over all voices per frame strobe,
// fetching a new note word from the shared pattern ROM when a voice expires.
module note_sequencer #(
  parameter int NUM_VOICES = 3,
  parameter int TRACK_LEN  = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_frame_stb,
  input  logic                  i_enable,
  input  logic                  i_restart,
  output logic [7:0]            o_rom_addr,
  input  logic [15:0]           i_rom_data,
  output logic [NUM_VOICES-1:0] o_load,
  output logic [5:0]            o_pitch,
  output logic [4:0]            o_duration,
  output logic [3:0]            o_instrument,
  output logic                  o_busy,
  output logic                  o_overrun
);

  localparam int VW = 2;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    CAPTURE,
    NEXT
  } state_t;

  state_t                state;
  logic [VW-1:0]         vidx;
  logic [7:0]            ptr [NUM_VOICES];
  logic [4:0]            rem [NUM_VOICES];
  logic [NUM_VOICES-1:0] load;
  logic [5:0]            pitch;
  logic [4:0]            duration;
  logic [3:0]            instrument;
  logic                  overrun;
  logic                  last_voice;
  logic                  wrap;

  function automatic logic [7:0] base_of(input int v);
    return 8'(v * TRACK_LEN);
  endfunction

  function automatic logic [7:0] last_of(input int v);
    return 8'(v * TRACK_LEN + TRACK_LEN - 1);
  endfunction

  assign last_voice = (vidx == VW'(NUM_VOICES - 1));
  assign wrap = i_rom_data[0] ||
                (ptr[vidx] == last_of(int'(vidx)));

  // Address is only presented while a voice with an expired note is checked,
  // so the synchronous ROM returns its word in the CAPTURE cycle.
  always_comb begin
    o_rom_addr = '0;
    if (state == CHECK && rem[vidx] == '0)
      o_rom_addr = ptr[vidx];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      vidx       <= '0;
      load       <= '0;
      pitch      <= '0;
      duration   <= '0;
      instrument <= '0;
      overrun    <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        ptr[v] <= base_of(v);
        rem[v] <= '0;
      end
    end else if (i_restart) begin
      state   <= IDLE;
      vidx    <= '0;
      load    <= '0;
      overrun <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        ptr[v] <= base_of(v);
        rem[v] <= '0;
      end
    end else begin
      load    <= '0;
      overrun <= i_frame_stb && (state != IDLE);
      unique case (state)
        IDLE: begin
          if (i_frame_stb && i_enable) begin
            vidx  <= '0;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (rem[vidx] != '0) begin
            rem[vidx] <= rem[vidx] - 5'd1;
            state     <= NEXT;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          pitch      <= i_rom_data[15:10];
          duration   <= i_rom_data[9:5];
          instrument <= i_rom_data[4:1];
          load[vidx] <= 1'b1;
          rem[vidx]  <= i_rom_data[9:5];
          if (wrap)
            ptr[vidx] <= base_of(int'(vidx));
          else
            ptr[vidx] <= ptr[vidx] + 8'd1;
          state <= NEXT;
        end
        NEXT: begin
          if (last_voice) begin
            state <= IDLE;
          end else begin
            vidx  <= vidx + VW'(1);
            state <= CHECK;
          end
        end
      endcase
    end
  end

  assign o_load       = load;
  assign o_pitch      = pitch;
  assign o_duration   = duration;
  assign o_instrument = instrument;
  assign o_overrun    = overrun;
  assign o_busy       = (state != IDLE);

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed vectors, corner sequences
// and random ROM contents against a per-voice track model.
module tb_note_sequencer;

  localparam int NV = 3;
  localparam int TL = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_stb;
  logic          enable;
  logic          restart;
  logic [7:0]    rom_addr;
  logic [15:0]   rom_data;
  logic [NV-1:0] load;
  logic [5:0]    pitch;
  logic [4:0]    duration;
  logic [3:0]    instrument;
  logic          busy;
  logic          overrun;

  note_sequencer #(.NUM_VOICES(NV), .TRACK_LEN(TL)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_frame_stb  (frame_stb),
    .i_enable     (enable),
    .i_restart    (restart),
    .o_rom_addr   (rom_addr),
    .i_rom_data   (rom_data),
    .o_load       (load),
    .o_pitch      (pitch),
    .o_duration   (duration),
    .o_instrument (instrument),
    .o_busy       (busy),
    .o_overrun    (overrun)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [256];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int checks = 0;
  int errors = 0;

  // track model
  int mptr [NV];
  int mrem [NV];
  int lp, ld, li;
  bit fetched [NV];
  int last_fetch [NV];
  int seen_pitch [NV];
  int scan_len;

  typedef struct {
    bit stb;
    bit en;
    bit rs;
    bit exp_busy;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mk(input int p, input int d,
                                     input int i, input int e);
    logic [15:0] w;
    w = {6'(p), 5'(d), 4'(i), 1'(e)};
    return w;
  endfunction

  task automatic model_rewind();
    for (int v = 0; v < NV; v++) begin
      mptr[v] = v * TL;
      mrem[v] = 0;
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("restart_busy", busy, 0);
    chk("restart_load", load, 0);
    model_rewind();
  endtask

  task automatic adv(input int ovr_at, inout int k);
    bit s;
    s = (k == ovr_at);
    frame_stb = s;
    step();
    frame_stb = 1'b0;
    k++;
    chk("overrun", overrun, s);
  endtask

  task automatic run_frame(input int ovr_at);
    int k;
    logic [15:0] w;
    for (int v = 0; v < NV; v++) fetched[v] = 0;
    frame_stb = 1'b1;
    step();
    frame_stb = 1'b0;
    chk("start_overrun", overrun, 0);
    if (!enable) begin
      for (int j = 0; j < 3; j++) begin
        chk("dis_busy", busy, 0);
        chk("dis_addr", rom_addr, 0);
        chk("dis_load", load, 0);
        step();
      end
      scan_len = 0;
      return;
    end
    k = 1;
    for (int v = 0; v < NV; v++) begin
      chk("busy", busy, 1);
      if (mrem[v] != 0) begin
        chk("count_addr", rom_addr, 0);
        mrem[v]--;
        adv(ovr_at, k);
        chk("count_busy", busy, 1);
        chk("count_load", load, 0);
        adv(ovr_at, k);
      end else begin
        chk("fetch_addr", rom_addr, mptr[v]);
        fetched[v] = 1;
        last_fetch[v] = mptr[v];
        w = rom[mptr[v]];
        adv(ovr_at, k);
        chk("cap_addr", rom_addr, 0);
        chk("cap_load", load, 0);
        adv(ovr_at, k);
        chk("load", load, 1 << v);
        chk("pitch", pitch, int'(w[15:10]));
        chk("duration", duration, int'(w[9:5]));
        chk("instrument", instrument, int'(w[4:1]));
        seen_pitch[v] = int'(pitch);
        lp = int'(w[15:10]);
        ld = int'(w[9:5]);
        li = int'(w[4:1]);
        mrem[v] = int'(w[9:5]);
        if (w[0] || mptr[v] == v * TL + TL - 1)
          mptr[v] = v * TL;
        else
          mptr[v]++;
        adv(ovr_at, k);
      end
    end
    scan_len = k - 1;
    chk("end_busy", busy, 0);
    chk("end_load", load, 0);
    chk("end_addr", rom_addr, 0);
    step();
    chk("idle_busy", busy, 0);
    chk("idle_load", load, 0);
    chk("idle_overrun", overrun, 0);
  endtask

  initial begin
    vec_t vecs [5];
    vecs[0] = '{stb: 0, en: 0, rs: 0, exp_busy: 0};
    vecs[1] = '{stb: 1, en: 0, rs: 0, exp_busy: 0};
    vecs[2] = '{stb: 1, en: 1, rs: 1, exp_busy: 0};
    vecs[3] = '{stb: 0, en: 1, rs: 0, exp_busy: 0};
    vecs[4] = '{stb: 1, en: 0, rs: 1, exp_busy: 0};

    for (int a = 0; a < 256; a++) rom[a] = '0;
    rst = 1'b1;
    frame_stb = 1'b0;
    enable = 1'b0;
    restart = 1'b0;
    lp = 0; ld = 0; li = 0;
    model_rewind();
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_load", load, 0);
    chk("rst_pitch", pitch, 0);
    chk("rst_dur", duration, 0);
    chk("rst_instr", instrument, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_overrun", overrun, 0);

    // idle vectors: gating by enable and restart priority
    foreach (vecs[i]) begin
      frame_stb = vecs[i].stb;
      enable = vecs[i].en;
      restart = vecs[i].rs;
      step();
      frame_stb = 1'b0;
      restart = 1'b0;
      chk("vec_busy", busy, vecs[i].exp_busy);
      chk("vec_load", load, 0);
      chk("vec_addr", rom_addr, 0);
      chk("vec_overrun", overrun, 0);
    end

    // directed track layout
    rom[8'h00] = 16'hA0C4;
    rom[8'h01] = mk(7, 0, 5, 0);
    rom[8'h40] = mk(10, 0, 1, 0);
    rom[8'h41] = mk(11, 0, 2, 0);
    rom[8'h42] = mk(12, 0, 3, 1);
    rom[8'h43] = mk(13, 0, 4, 0);
    for (int i = 0; i < TL; i++) rom[8'h80 + i] = mk(i + 1, 0, i % 16, 0);
    enable = 1'b1;
    for (int n = 1; n <= 65; n++) begin
      run_frame(-1);
      if (n == 1) begin
        chk("f1_len", scan_len, 9);
        chk("f1_v0", last_fetch[0], 8'h00);
        chk("f1_v1", last_fetch[1], 8'h40);
        chk("f1_v2", last_fetch[2], 8'h80);
        chk("f1_pitch", seen_pitch[0], 40);
        chk("f1_dur", mrem[0], 6);
      end
      if (n == 2) chk("f2_v0_skip", fetched[0], 0);
      if (n == 3) chk("f3_v1", last_fetch[1], 8'h42);
      if (n == 4) chk("f4_v1_wrap", last_fetch[1], 8'h40);
      if (n == 8) chk("f8_v0", last_fetch[0], 8'h01);
      if (n == 64) chk("f64_v2", last_fetch[2], 8'hBF);
      if (n == 65) chk("f65_v2_wrap", last_fetch[2], 8'h80);
    end

    // strobe three cycles into a scan
    run_frame(3);

    // duration 2 on voice 0
    do_restart();
    rom[8'h00] = mk(5, 2, 1, 0);
    rom[8'h01] = mk(6, 0, 3, 0);
    for (int n = 1; n <= 4; n++) begin
      run_frame(-1);
      chk("d2_fetch", fetched[0], (n == 1 || n == 4) ? 1 : 0);
    end
    chk("d2_addr", last_fetch[0], 8'h01);

    // restart while voice 0 is in CAPTURE
    do_restart();
    frame_stb = 1'b1;
    step();
    frame_stb = 1'b0;
    chk("rc_addr", rom_addr, 8'h00);
    step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("rc_load", load, 0);
    chk("rc_busy", busy, 0);
    chk("rc_pitch", pitch, lp);
    chk("rc_dur", duration, ld);
    model_rewind();
    run_frame(-1);
    chk("rc_v0", last_fetch[0], 8'h00);
    chk("rc_v1", last_fetch[1], 8'h40);
    chk("rc_v2", last_fetch[2], 8'h80);

    // enable low then resume from saved pointers
    enable = 1'b0;
    for (int n = 0; n < 3; n++) run_frame(-1);
    enable = 1'b1;
    run_frame(-1);
    chk("resume_v1", last_fetch[1], 8'h41);

    // reset mid-scan
    frame_stb = 1'b1;
    step();
    frame_stb = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_load", load, 0);
    chk("mrst_pitch", pitch, 0);
    chk("mrst_instr", instrument, 0);
    model_rewind();
    run_frame(-1);

    // random tracks, random gating and overrun strobes
    for (int a = 0; a < 256; a++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 1) == 1) w[9:7] = 3'b000;
      w[0] = ($urandom_range(0, 7) == 0);
      rom[a] = w;
    end
    do_restart();
    for (int n = 0; n < 80; n++) begin
      enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0)
        run_frame(int'($urandom_range(1, 5)));
      else
        run_frame(-1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Multi-voice track sequencer that walks per-voice note lists in a shared 16-bit pattern ROM and feeds note_player instances with pitch/duration/instrument plus a one-cycle load pulse.
- Runs one scan over all voices per frame strobe, fetching a new note word only for voices whose current note has expired.
- Sits between the frame timer and the bank of note players; owns the pattern ROM read port.

Parameters:
- NUM_VOICES, 3, number of voices sequenced (1..4).
- TRACK_LEN, 64, words per voice track. Voice v's track base = v*TRACK_LEN. NUM_VOICES*TRACK_LEN must be <= 256.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_frame_stb  in  1  one-cycle frame tick
- i_enable  in  1  allow scans to start
- i_restart  in  1  one-cycle pulse: rewind all tracks
- o_rom_addr  out  8  pattern ROM address (ROM is synchronous, 1-cycle read latency)
- i_rom_data  in  16  pattern ROM data; note word = [15:10] pitch, [9:5] duration, [4:1] instrument, [0] end-of-track
- o_load  out  NUM_VOICES  one-hot, registered one-cycle load pulse per voice
- o_pitch  out  6  note pitch for the voice being loaded
- o_duration  out  5  note duration
- o_instrument  out  4  note instrument
- o_busy  out  1  high while a scan is in progress
- o_overrun  out  1  one-cycle pulse when a frame strobe arrives while busy

Behaviour:
- Reset clears all outputs to 0 and sets state IDLE. Per voice v, reset sets ptr[v]=v*TRACK_LEN and remaining[v]=0.
- The first enabled frame therefore fetches every voice.

State machine (vidx = current voice index):
- IDLE: if i_frame_stb && i_enable, then vidx=0 and go to CHECK. Strobe with enable low is ignored, with no overrun.
- CHECK: if remaining[vidx]!=0, decrement it and go to NEXT. Otherwise drive o_rom_addr=ptr[vidx] this cycle and go to CAPTURE.
- CAPTURE: i_rom_data is valid.
  - Register pitch/duration/instrument into the outputs and set o_load[vidx]=1 for exactly the following cycle.
  - remaining[vidx] = duration field. Duration 0 causes a re-fetch on the next frame.
  - If bit0 is set, or ptr is the last word of the track (base+TRACK_LEN-1), ptr[vidx]=base; else ptr[vidx]+1.
  - Go to NEXT.
- NEXT: if vidx==NUM_VOICES-1, go to IDLE; else vidx+1 and go to CHECK.

Output and timing rules:
- o_rom_addr is 0 in every state except the CHECK fetch cycle.
- o_pitch/o_duration/o_instrument hold their last loaded values between loads.
- o_load is all zeros except for the single pulse cycle.
- o_busy=1 in every state except IDLE.
- Scan length: 2 cycles for each expired voice, 1 cycle for each counting voice, plus 1 cycle of NEXT per voice. A full scan of 3 voices takes at most 9 cycles.

Boundary conditions:
- Frame strobe while busy: strobe dropped, o_overrun pulses next cycle, scan continues unaffected.
- i_restart (any state, priority over everything except i_rst):
  - Go to IDLE, rewind all ptr to their bases, clear all remaining to 0.
  - Suppress any pending load: o_load=0 next cycle.
  - Outputs pitch/duration/instrument retained.
- i_restart coincident with i_frame_stb in IDLE: the restart wins and no scan starts that cycle.
- i_enable deasserted mid-scan: the current scan completes. Only scan start is gated.
- Reset mid-scan: immediate return to the reset state. No load pulse is emitted.
- End-of-track word: the word itself is played, and the wrap applies to the next fetch.

Test Plan:
- Reset, enable, one strobe, ROM voice0 word0=0xA0C4, voice1/2 words nonzero -> voice0 fetch at addr 0x00, o_load=001 with pitch=40, dur=6, instr=2. Then addr 0x40 and 0x80 fetches with o_load=010 and 100; o_busy high for 9 cycles.
- Voice0 duration 2 -> no fetch of voice0 on strobes 2 and 3, fetch at addr 0x01 on strobe 4. Other voices with duration 0 fetch every frame.
- Voice1 word at 0x42 has bit0=1 -> the next voice1 fetch is at 0x40. Separately, a voice2 track with no end flag wraps from 0xBF to 0x80.
- Strobe asserted 3 cycles into a scan -> o_overrun single pulse, exactly one scan completes, no extra loads.
- i_restart mid-scan in CAPTURE -> no o_load that cycle, next enabled strobe fetches 0x00/0x40/0x80.
- i_enable low with strobes -> o_busy stays 0, no ROM fetch addresses and no loads. Raising enable resumes from the saved pointers.
